costas_lock_ctrl: RTL and testbench

COSTAS_LOCK_CTRL -- requirements
Module: costas_lock_ctrl

---
 rtl/bpsk_ctrl_pkg.sv | 31 +++
 rtl/costas_lock_ctrl_metric_acc.sv | 66 ++++++
 rtl/costas_lock_ctrl.sv | 169 ++++++++++++++++
 tb/tb_costas_lock_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bpsk_ctrl_pkg.sv
// bpsk_ctrl_pkg: shared definitions for the Costas lock controller.
//   state_t    - controller FSM states (IDLE..LOCKED encoded 0..4)
//   GAIN_*     - gain_sel codes driven to the loop filter
//   METRIC_W   - width of the signed window metric
//   abs_sat()  - 16-bit absolute value with -32768 clamped to 32767
package bpsk_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SWEEP  = 3'd2,
        S_TRACK  = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    localparam logic [1:0] GAIN_OFF    = 2'd0;
    localparam logic [1:0] GAIN_WIDE   = 2'd1;
    localparam logic [1:0] GAIN_NARROW = 2'd2;

    localparam int unsigned METRIC_W = 24;

    function automatic logic [15:0] abs_sat(input logic signed [15:0] x);
        if (x == 16'sh8000)
            return 16'h7fff;
        else if (x < 0)
            return unsigned'(-x);
        else
            return unsigned'(x);
    endfunction

endpackage

// File: rtl/costas_lock_ctrl_metric_acc.sv
// lock_metric_acc: accumulates (|I| - |Q|) over 2^WIN_LOG2 qualified samples.
//   clk, rst_n      - clock, synchronous active-low reset
//   en              - accumulate enable; low discards any partial window
//   sample_en       - qualifies i_filt/q_filt
//   i_filt, q_filt  - signed 16-bit filtered I/Q
//   done            - high in the cycle the final sample of a window is presented
//   win_metric      - completed window sum (valid while done), saturated to METRIC_W
//   metric          - registered last completed window metric
module lock_metric_acc
    import bpsk_ctrl_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       sample_en,
    input  logic signed [15:0]         i_filt,
    input  logic signed [15:0]         q_filt,
    output logic                       done,
    output logic signed [METRIC_W-1:0] win_metric,
    output logic signed [METRIC_W-1:0] metric
);

    // Accumulator is kept at least one bit wider than the metric so the
    // saturation bounds below are representable.
    localparam int unsigned ACC_W = (WIN_LOG2 + 17 > METRIC_W) ? WIN_LOG2 + 17 : METRIC_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (METRIC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic [WIN_LOG2-1:0]     cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [16:0]      diff;

    always_comb begin
        diff = $signed({1'b0, abs_sat(i_filt)}) - $signed({1'b0, abs_sat(q_filt)});
        sum  = acc + ACC_W'(diff);
        done = en && sample_en && (cnt == '1);
        if (sum > SAT_HI)
            win_metric = METRIC_W'(SAT_HI);
        else if (sum < SAT_LO)
            win_metric = METRIC_W'(SAT_LO);
        else
            win_metric = METRIC_W'(sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            metric <= '0;
        end else begin
            if (done)
                metric <= win_metric;
            if (!en) begin
                cnt <= '0;
                acc <= '0;
            end else if (sample_en) begin
                cnt <= cnt + WIN_LOG2'(1);
                acc <= done ? '0 : sum;
            end
        end
    end

endmodule

// File: rtl/costas_lock_ctrl.sv
// costas_lock_ctrl: acquisition/lock controller for a BPSK Costas loop.
// Sweeps the NCO frequency control word around INIT_FREQ until the window
// metric sum(|I|-|Q|) passes LOCK_THR, then narrows the loop and reports lock.
//   clk, rst_n        - clock, synchronous active-low reset
//   start, abort      - one-cycle acquisition start / return-to-IDLE pulses
//   sample_en         - qualifies i_filt/q_filt
//   i_filt, q_filt    - signed 16-bit FIR outputs
//   fcw_base          - FCW seed for the loop filter
//   loop_en, gain_sel - loop filter enable and bandwidth (0 off, 1 wide, 2 narrow)
//   locked, state_o   - lock status and current FSM encoding
//   metric_o          - last completed window metric
// Build option: define COSTAS_LOCK_CTRL_HYST_EN to require LOSS_CNT consecutive
// failing windows before unlocking (default: a single failing window unlocks).
module costas_lock_ctrl
    import bpsk_ctrl_pkg::*;
#(
    parameter logic [31:0]        INIT_FREQ   = 32'd42949673,
    parameter logic [31:0]        SWEEP_STEP  = 32'd429497,
    parameter int unsigned        SWEEP_STEPS = 16,
    parameter int unsigned        WIN_LOG2    = 8,
    parameter int unsigned        SETTLE_CYC  = 128,
    parameter logic signed [23:0] LOCK_THR    = 24'sd1048576,
    parameter int unsigned        LOSS_CNT    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       sample_en,
    input  logic signed [15:0]         i_filt,
    input  logic signed [15:0]         q_filt,
    output logic [31:0]                fcw_base,
    output logic                       loop_en,
    output logic [1:0]                 gain_sel,
    output logic                       locked,
    output logic [2:0]                 state_o,
    output logic signed [METRIC_W-1:0] metric_o
);

`ifdef COSTAS_LOCK_CTRL_HYST_EN
    localparam int unsigned LOSS_LIM = LOSS_CNT;
`else
    localparam int unsigned LOSS_LIM = 1;
`endif

    localparam int unsigned SW = $clog2(2 * SWEEP_STEPS + 1);
    localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned FW = $clog2(LOSS_LIM + 1);

    state_t                    state, state_nxt;
    logic [31:0]               fcw_nxt, fcw_step, offs;
    logic [SW-1:0]             step_idx, step_nxt, step_adv;
    logic [CW-1:0]             settle_cnt, settle_nxt;
    logic [FW-1:0]             fail_cnt, fail_nxt;
    logic                      acc_en, win_done, win_pass;
    logic signed [METRIC_W-1:0] win_metric;

    assign acc_en = (state == S_SWEEP) || (state == S_TRACK) || (state == S_LOCKED);

    lock_metric_acc #(
        .WIN_LOG2(WIN_LOG2)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (acc_en),
        .sample_en (sample_en),
        .i_filt    (i_filt),
        .q_filt    (q_filt),
        .done      (win_done),
        .win_metric(win_metric),
        .metric    (metric_o)
    );

    assign win_pass = (win_metric >= LOCK_THR);

    // Next sweep point: step_idx counts failed steps; even index -> +, odd -> -,
    // magnitude (idx/2 + 1) steps. After 2*SWEEP_STEPS points, back to INIT_FREQ.
    always_comb begin
        offs = SWEEP_STEP * (32'(step_idx >> 1) + 32'd1);
        if (step_idx == SW'(2 * SWEEP_STEPS)) begin
            fcw_step = INIT_FREQ;
            step_adv = '0;
        end else begin
            fcw_step = step_idx[0] ? INIT_FREQ - offs : INIT_FREQ + offs;
            step_adv = step_idx + SW'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        fcw_nxt    = fcw_base;
        step_nxt   = step_idx;
        settle_nxt = '0;
        fail_nxt   = fail_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    fcw_nxt   = INIT_FREQ;
                    step_nxt  = '0;
                    fail_nxt  = '0;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == CW'(SETTLE_CYC - 1))
                    state_nxt = S_SWEEP;
                else
                    settle_nxt = settle_cnt + CW'(1);
            end
            S_SWEEP, S_TRACK: begin
                if (win_done) begin
                    if (win_pass) begin
                        state_nxt = (state == S_SWEEP) ? S_TRACK : S_LOCKED;
                        fail_nxt  = '0;
                    end else begin
                        fcw_nxt   = fcw_step;
                        step_nxt  = step_adv;
                        state_nxt = S_SETTLE;
                    end
                end
            end
            S_LOCKED: begin
                if (win_done) begin
                    if (win_pass) begin
                        fail_nxt = '0;
                    end else if (fail_cnt == FW'(LOSS_LIM - 1)) begin
                        fail_nxt  = '0;
                        state_nxt = S_SETTLE;
                    end else begin
                        fail_nxt = fail_cnt + FW'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            fcw_base   <= INIT_FREQ;
            step_idx   <= '0;
            settle_cnt <= '0;
            fail_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            fcw_base   <= fcw_nxt;
            step_idx   <= step_nxt;
            settle_cnt <= settle_nxt;
            fail_cnt   <= fail_nxt;
        end
    end

    // Outputs decode the registered state, so locked moves on the same edge
    // that registers the completing window's metric.
    always_comb begin
        loop_en  = acc_en;
        locked   = (state == S_LOCKED);
        state_o  = state;
        case (state)
            S_SETTLE, S_SWEEP:  gain_sel = GAIN_WIDE;
            S_TRACK, S_LOCKED:  gain_sel = GAIN_NARROW;
            default:            gain_sel = GAIN_OFF;
        endcase
    end

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// tb_costas_lock_ctrl: directed self-checking bench for costas_lock_ctrl
// (default parameters). Honours COSTAS_LOCK_CTRL_HYST_EN for the loss scenario.
module tb_costas_lock_ctrl;
    import bpsk_ctrl_pkg::*;

    localparam logic [31:0] INIT = 32'd42949673;
    localparam logic [31:0] STEP = 32'd429497;

    logic               clk = 1'b0;
    logic               rst_n, start, abort, sample_en;
    logic signed [15:0] i_filt, q_filt;
    logic [31:0]        fcw_base;
    logic               loop_en, locked;
    logic [1:0]         gain_sel;
    logic [2:0]         state_o;
    logic signed [23:0] metric_o;

    int errors = 0;
    int checks = 0;

    costas_lock_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .sample_en(sample_en),
        .i_filt   (i_filt),
        .q_filt   (q_filt),
        .fcw_base (fcw_base),
        .loop_en  (loop_en),
        .gain_sel (gain_sel),
        .locked   (locked),
        .state_o  (state_o),
        .metric_o (metric_o)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // start is sampled by the next edge ("edge 1"); SETTLE follows it.
    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
        checks++; if (fcw_base !== INIT) begin errors++; $display("FAIL reset_fcw: got %0d want %0d", fcw_base, INIT); end
        checks++; if (loop_en !== 1'b0) begin errors++; $display("FAIL reset_loop_en: got %0b want 0", loop_en); end
        checks++; if (gain_sel !== 2'd0) begin errors++; $display("FAIL reset_gain: got %0d want 0", gain_sel); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
        checks++; if (metric_o !== 24'sd0) begin errors++; $display("FAIL reset_metric: got %0d want 0", metric_o); end
    endtask

    // I=8000, Q=0: each window sums 8000*256 = 2048000 >= 1048576.
    // Edge 1 takes start, edges 2..129 settle, windows finish at 385 and 641;
    // counting the start cycle as the first, locked is high in cycle 642.
    task automatic test_lock_acquire;
        i_filt = 16'sd8000; q_filt = 16'sd0; sample_en = 1'b1;
        do_reset();
        pulse_start();                                   // edge 1
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL acq_settle: got %0d want 1", state_o); end
        tick(49);                                        // edge 50
        start = 1'b1; tick(1); start = 1'b0;             // edge 51, ignored
        tick(77);                                        // edge 128
        checks++; if (state_o !== 3'd1 || loop_en !== 1'b0) begin errors++; $display("FAIL acq_settle_end: state %0d loop_en %0b want 1/0", state_o, loop_en); end
        tick(1);                                         // edge 129
        checks++; if (state_o !== 3'd2 || loop_en !== 1'b1 || gain_sel !== 2'd1) begin errors++; $display("FAIL acq_sweep: state %0d loop_en %0b gain %0d want 2/1/1", state_o, loop_en, gain_sel); end
        tick(256);                                       // edge 385
        checks++; if (state_o !== 3'd3 || gain_sel !== 2'd2) begin errors++; $display("FAIL acq_track: state %0d gain %0d want 3/2", state_o, gain_sel); end
        checks++; if (metric_o !== 24'sd2048000) begin errors++; $display("FAIL acq_metric: got %0d want 2048000", metric_o); end
        tick(255);                                       // edge 640
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL acq_early_lock: got %0b want 0", locked); end
        tick(1);                                         // edge 641
        checks++; if (locked !== 1'b1 || state_o !== 3'd4) begin errors++; $display("FAIL acq_locked: locked %0b state %0d want 1/4", locked, state_o); end
        checks++; if (fcw_base !== INIT) begin errors++; $display("FAIL acq_fcw: got %0d want %0d", fcw_base, INIT); end
    endtask

    // Continues from LOCKED (edge 641): next window (edges 642..897) fails.
    task automatic test_loss;
        i_filt = 16'sd0; q_filt = 16'sd8000;
        tick(255);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_before: got %0b want 1", locked); end
        tick(1);
        checks++; if (metric_o !== -24'sd2048000) begin errors++; $display("FAIL loss_metric: got %0d want -2048000", metric_o); end
`ifdef COSTAS_LOCK_CTRL_HYST_EN
        checks++; if (locked !== 1'b1 || state_o !== 3'd4) begin errors++; $display("FAIL loss_hyst_hold: locked %0b state %0d want 1/4", locked, state_o); end
        tick(2 * 256);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_hyst_third: got %0b want 1", locked); end
        tick(256);
        checks++; if (locked !== 1'b0 || gain_sel !== 2'd1 || state_o !== 3'd1) begin errors++; $display("FAIL loss_hyst_drop: locked %0b gain %0d state %0d want 0/1/1", locked, gain_sel, state_o); end
`else
        checks++; if (locked !== 1'b0 || gain_sel !== 2'd1 || state_o !== 3'd1) begin errors++; $display("FAIL loss_drop: locked %0b gain %0d state %0d want 0/1/1", locked, gain_sel, state_o); end
`endif
        checks++; if (fcw_base !== INIT) begin errors++; $display("FAIL loss_fcw: got %0d want %0d", fcw_base, INIT); end
    endtask

    // abort presented together with the final sample of the first window.
    task automatic test_abort_window;
        i_filt = 16'sd8000; q_filt = 16'sd0;
        do_reset();
        pulse_start();
        tick(128 + 255);                                 // edge 384
        abort = 1'b1;
        tick(1);                                         // edge 385: done + abort
        abort = 1'b0;
        checks++; if (state_o !== 3'd0 || loop_en !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL abort_window: state %0d loop_en %0b locked %0b want 0/0/0", state_o, loop_en, locked); end
        tick(300);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL abort_stays_idle: got %0d want 0", state_o); end
    endtask

    // |-32768| clamps to 32767: 32767*256 = 8388352.
    task automatic test_sat_metric;
        i_filt = -16'sd32768; q_filt = 16'sd0;
        do_reset();
        pulse_start();
        tick(128 + 256);
        checks++; if (metric_o !== 24'sd8388352) begin errors++; $display("FAIL sat_metric: got %0d want 8388352", metric_o); end
    endtask

    task automatic test_reset_mid_window;
        i_filt = 16'sd8000; q_filt = 16'sd0;
        do_reset();
        pulse_start();
        tick(128 + 100);                                 // 100 samples into the window
        rst_n = 1'b0;
        tick(1);
        checks++; if (state_o !== 3'd0 || loop_en !== 1'b0 || gain_sel !== 2'd0 || locked !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: state %0d loop_en %0b gain %0d locked %0b want 0/0/0/0", state_o, loop_en, gain_sel, locked); end
        checks++; if (metric_o !== 24'sd0 || fcw_base !== INIT) begin errors++; $display("FAIL rst_mid_data: metric %0d fcw %0d want 0/%0d", metric_o, fcw_base, INIT); end
        rst_n = 1'b1;
        // Fresh window: (100 - 40) * 256 = 15360.
        i_filt = 16'sd100; q_filt = -16'sd40;
        pulse_start();
        tick(128 + 256);
        checks++; if (metric_o !== 24'sd15360) begin errors++; $display("FAIL rst_mid_window: got %0d want 15360", metric_o); end
    endtask

    // Every window fails; one step per 128 + 256 cycles. Points +1,-1,...,+16,-16
    // times STEP, then INIT, then +1 again.
    task automatic test_sweep;
        logic [31:0] want;
        int unsigned k;
        i_filt = 16'sd0; q_filt = 16'sd8000;
        do_reset();
        pulse_start();
        for (int unsigned n = 1; n <= 34; n++) begin
            tick(128 + 256);
            k = (n - 1) % 33;
            if (k == 32)
                want = INIT;
            else if (k % 2 == 0)
                want = INIT + (k / 2 + 1) * STEP;
            else
                want = INIT - (k / 2 + 1) * STEP;
            checks++; if (fcw_base !== want || state_o !== 3'd1) begin errors++; $display("FAIL sweep_step%0d: fcw %0d state %0d want %0d/1", n, fcw_base, state_o, want); end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sample_en = 1'b0;
        i_filt = '0; q_filt = '0;
        test_reset();
        test_lock_acquire();
        test_loss();
        test_abort_window();
        test_sat_metric();
        test_reset_mid_window();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
